// File: rtl/blood_ph_monitor_controller_if.sv
// Sensor handshake, operator controls and alarm-panel outputs of the blood-pH monitor.
// The master modport is the controller; the slave modport is the sensor/panel side.
interface blood_ph_monitor_controller_if;
  logic       enable;
  logic       sampleValid;
  logic [3:0] sampleData;
  logic       alarmAck;
  logic       sampleReq;
  logic [3:0] phLatched;
  logic       alarmP;
  logic       warningQ;
  logic       sensorFault;
  logic       newSample;

  modport master (
    input  enable, sampleValid, sampleData, alarmAck,
    output sampleReq, phLatched, alarmP, warningQ, sensorFault, newSample
  );

  modport slave (
    output enable, sampleValid, sampleData, alarmAck,
    input  sampleReq, phLatched, alarmP, warningQ, sensorFault, newSample
  );
endinterface

// File: rtl/blood_ph_monitor_controller.sv
// Periodic blood-pH acquisition: timed sensor request, req/valid handshake with timeout,
// P/Q range classification and sticky, acknowledgeable alarm/warning/fault flags.
module blood_ph_monitor_controller #(
  parameter int unsigned SAMPLE_PERIOD = 16,
  parameter int unsigned TIMEOUT       = 8,
  parameter int unsigned CONFIRM_COUNT = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  blood_ph_monitor_controller_if.master   bus
);

  localparam int unsigned TW = $clog2(SAMPLE_PERIOD) + 1;
  localparam int unsigned OW = $clog2(TIMEOUT) + 1;
  localparam int unsigned CW = $clog2(CONFIRM_COUNT) + 1;

  typedef enum logic [1:0] {IDLE, REQUEST, EVAL} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [OW-1:0]   timeout_q, timeout_d;
  logic [CW-1:0]   p_cnt_q, p_cnt_d;
  logic [CW-1:0]   q_cnt_q, q_cnt_d;
  logic [3:0]      ph_latched_q, ph_latched_d;
  logic            sample_req_q, sample_req_d;
  logic            alarm_p_q, alarm_p_d;
  logic            warning_q_q, warning_q_d;
  logic            sensor_fault_q, sensor_fault_d;
  logic            new_sample_q, new_sample_d;

  logic            timer_hit;
  logic            timeout_hit;
  logic            p_abn;
  logic            q_abn;

  assign timer_hit   = (timer_q == TW'(SAMPLE_PERIOD - 1));
  assign timeout_hit = (timeout_q == OW'(TIMEOUT - 1));
  assign p_abn       = (ph_latched_q == 4'd7) || (ph_latched_q == 4'd8);
  assign q_abn       = (ph_latched_q >= 4'd6) && (ph_latched_q <= 4'd9);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      timeout_q      <= '0;
      p_cnt_q        <= '0;
      q_cnt_q        <= '0;
      ph_latched_q   <= '0;
      sample_req_q   <= 1'b0;
      alarm_p_q      <= 1'b0;
      warning_q_q    <= 1'b0;
      sensor_fault_q <= 1'b0;
      new_sample_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      timeout_q      <= timeout_d;
      p_cnt_q        <= p_cnt_d;
      q_cnt_q        <= q_cnt_d;
      ph_latched_q   <= ph_latched_d;
      sample_req_q   <= sample_req_d;
      alarm_p_q      <= alarm_p_d;
      warning_q_q    <= warning_q_d;
      sensor_fault_q <= sensor_fault_d;
      new_sample_q   <= new_sample_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable && timer_hit) state_d = REQUEST;
      REQUEST: begin
        if (!bus.enable)          state_d = IDLE;
        else if (bus.sampleValid) state_d = EVAL;
        else if (timeout_hit)     state_d = IDLE;
      end
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d        = timer_q;
    timeout_d      = timeout_q;
    p_cnt_d        = p_cnt_q;
    q_cnt_d        = q_cnt_q;
    ph_latched_d   = ph_latched_q;
    sample_req_d   = sample_req_q;
    new_sample_d   = 1'b0;
    // Ack clears first; any set below overrides it in the same cycle.
    alarm_p_d      = bus.alarmAck ? 1'b0 : alarm_p_q;
    warning_q_d    = bus.alarmAck ? 1'b0 : warning_q_q;
    sensor_fault_d = bus.alarmAck ? 1'b0 : sensor_fault_q;

    case (state_q)
      IDLE: begin
        if (!bus.enable) begin
          timer_d = '0;
        end else if (timer_hit) begin
          timer_d      = '0;
          sample_req_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REQUEST: begin
        timeout_d = timeout_q + OW'(1);
        if (!bus.enable) begin
          sample_req_d = 1'b0;
          timeout_d    = '0;
        end else if (bus.sampleValid) begin
          ph_latched_d = bus.sampleData;
          sample_req_d = 1'b0;
          timeout_d    = '0;
        end else if (timeout_hit) begin
          sensor_fault_d = 1'b1;
          sample_req_d   = 1'b0;
          timeout_d      = '0;
        end
      end
      EVAL: begin
        if (!p_abn)                             p_cnt_d = '0;
        else if (p_cnt_q != CW'(CONFIRM_COUNT)) p_cnt_d = p_cnt_q + CW'(1);
        if (!q_abn)                             q_cnt_d = '0;
        else if (q_cnt_q != CW'(CONFIRM_COUNT)) q_cnt_d = q_cnt_q + CW'(1);
        if (p_cnt_d == CW'(CONFIRM_COUNT)) alarm_p_d   = 1'b1;
        if (q_cnt_d == CW'(CONFIRM_COUNT)) warning_q_d = 1'b1;
        new_sample_d = 1'b1;
        timer_d      = '0;
      end
      default: ;
    endcase
  end

  assign bus.sampleReq   = sample_req_q;
  assign bus.phLatched   = ph_latched_q;
  assign bus.alarmP      = alarm_p_q;
  assign bus.warningQ    = warning_q_q;
  assign bus.sensorFault = sensor_fault_q;
  assign bus.newSample   = new_sample_q;

endmodule
